anc_i2s_tx: RTL and testbench

//  Output end of the ANC datapath: buffers the FIR output stream (out_sample/out_valid,
//  no backpressure) in a small FIFO and serialises it to an I2S (Philips) DAC link.
//  One mono sample per frame is sent on both left and right. Sits after the ANC top level.

---
 rtl/anc_pkg.sv | 8 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/anc_i2s_tx.sv | 142 ++++++++++++++
 tb/tb_anc_i2s_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// Types and constants shared by the ANC controller, FIR and I2S output stage.
package anc_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push while full is accepted only when a
// pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr_q];
    assign level   = level_q;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/anc_i2s_tx.sv
// ANC output stage: buffers the FIR sample stream and serialises one mono sample per
// I2S (Philips) frame, duplicated on left and right.
module anc_i2s_tx
    import anc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BCLK_DIV   = 8,
    parameter int unsigned WORD_BITS  = SAMPLE_W,
    parameter int unsigned SLOT_BITS  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [WORD_BITS-1:0]          in_sample,
    input  logic                          in_valid,
    input  logic                          clr_flags,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned DW = $clog2(BCLK_DIV);
    localparam int unsigned FW = 2 * SLOT_BITS;
    localparam int unsigned PW = $clog2(FW);

    logic [DW-1:0]        div_q;
    logic                 bclk_q;
    logic                 lrclk_q;
    logic                 sdata_q;
    logic [PW-1:0]        pos_q;
    logic                 started_q;
    logic [FW-1:0]        frame_q;
    logic                 last_q;
    logic [WORD_BITS-1:0] hold_q;
    logic                 ovf_q;
    logic                 unf_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WORD_BITS-1:0] fifo_rdata;

    logic                 div_wrap;
    logic                 fall;
    logic                 frame_start;
    logic                 pop;
    logic [PW-1:0]        pos_next;
    logic [WORD_BITS-1:0] new_sample;
    logic [SLOT_BITS-1:0] slot;
    logic [FW-1:0]        new_frame;

    sync_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (in_sample),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Edge decode, pop decision and the frame word built from the popped/held sample.
    always_comb begin
        div_wrap    = enable && (div_q == DW'(BCLK_DIV - 1));
        fall        = div_wrap && bclk_q;
        frame_start = fall && (!started_q || (pos_q == PW'(FW - 1)));
        pop         = frame_start && !fifo_empty;
        pos_next    = frame_start ? '0 : pos_q + PW'(1);
        new_sample  = pop ? fifo_rdata : hold_q;
        slot        = '0;
        slot[SLOT_BITS-1 -: WORD_BITS] = new_sample;
        new_frame   = {slot, slot};
    end

    // Serial link: divider, frame position, shift register and hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            pos_q     <= '0;
            started_q <= 1'b0;
            frame_q   <= '0;
            last_q    <= 1'b0;
            hold_q    <= '0;
        end else if (!enable) begin
            // Frame in flight is abandoned; FIFO, hold and last bit are kept.
            div_q     <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            pos_q     <= '0;
            started_q <= 1'b0;
        end else begin
            div_q <= div_wrap ? '0 : div_q + DW'(1);
            if (div_wrap) begin
                bclk_q <= ~bclk_q;
            end
            if (fall) begin
                started_q <= 1'b1;
                pos_q     <= pos_next;
                lrclk_q   <= (pos_next >= PW'(SLOT_BITS));
                if (frame_start) begin
                    // One-bit delay: previous frame's final bit goes out at p=0.
                    sdata_q <= last_q;
                    frame_q <= new_frame;
                    last_q  <= new_frame[0];
                    hold_q  <= new_sample;
                end else begin
                    sdata_q <= frame_q[FW-1];
                    frame_q <= {frame_q[FW-2:0], 1'b0};
                end
            end
        end
    end

    // Sticky flags; a set event in the same cycle as clr_flags wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (in_valid && fifo_full && !pop) || (ovf_q && !clr_flags);
            unf_q <= (frame_start && fifo_empty) || (unf_q && !clr_flags);
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_anc_i2s_tx.sv
// Bench for anc_i2s_tx: per-cycle comparison against a time-based frame model,
// a vector table for FIFO fill, and directed corner-case sequences.
module tb_anc_i2s_tx;

    localparam int B  = 2;
    localparam int S  = 32;
    localparam int D  = 4;
    localparam int FW = 2 * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        clr_flags = 1'b0;
    logic [15:0] in_sample = '0;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow;
    logic [2:0]  fifo_level;

    // Second instance with SLOT_BITS = WORD_BITS for the one-bit-delay spill case.
    logic        en16 = 1'b0;
    logic        v16 = 1'b0;
    logic [15:0] s16 = '0;
    logic        bclk16, lrclk16, sdata16, ovf16, unf16;
    logic [2:0]  lvl16;

    anc_i2s_tx #(
        .FIFO_DEPTH (D),
        .BCLK_DIV   (B),
        .WORD_BITS  (16),
        .SLOT_BITS  (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .clr_flags  (clr_flags),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdata  (i2s_sdata),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    anc_i2s_tx #(
        .FIFO_DEPTH (D),
        .BCLK_DIV   (B),
        .WORD_BITS  (16),
        .SLOT_BITS  (16)
    ) dut16 (
        .clk        (clk),
        .rst        (rst),
        .enable     (en16),
        .in_sample  (s16),
        .in_valid   (v16),
        .clr_flags  (1'b0),
        .i2s_bclk   (bclk16),
        .i2s_lrclk  (lrclk16),
        .i2s_sdata  (sdata16),
        .fifo_level (lvl16),
        .overflow   (ovf16),
        .underflow  (unf16)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model state.
    int          t;
    logic [15:0] q[$];
    logic [15:0] m_hold;
    logic [63:0] m_word;
    bit          e_bclk, e_lr, e_sd, e_ovf, e_unf;
    int          fall_p;
    int          fall_frame;

    typedef struct {
        bit          en;
        bit          v;
        bit          clr;
        logic [15:0] s;
        logic [2:0]  lvl;
        bit          ovf;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [63:0] build(input logic [15:0] s);
        return {s, 16'h0000, s, 16'h0000};
    endfunction

    task automatic model_reset();
        t = 0;
        q.delete();
        m_hold = '0;
        m_word = '0;
        e_bclk = 0; e_lr = 0; e_sd = 0; e_ovf = 0; e_unf = 0;
        fall_p = -1;
        fall_frame = -1;
    endtask

    // t counts enabled clocks; bclk is a square wave of period 2B in t, falls every 2B.
    task automatic model_edge(input bit en, input bit v, input bit clr, input logic [15:0] s);
        bit set_unf = 0;
        bit set_ovf = 0;
        int n;
        int p;
        fall_p = -1;
        if (en) begin
            t++;
            e_bclk = ((t / B) % 2) == 1;
            if (t % (2 * B) == 0) begin
                n = t / (2 * B) - 1;
                p = n % FW;
                fall_p = p;
                fall_frame = n / FW;
                if (p == 0) begin
                    e_sd = m_word[0];
                    if (q.size() > 0) m_hold = q.pop_front();
                    else set_unf = 1;
                    m_word = build(m_hold);
                    e_lr = 0;
                end else begin
                    e_sd = m_word[FW - p];
                    e_lr = (p >= S);
                end
            end
        end else begin
            t = 0;
            e_bclk = 0; e_lr = 0; e_sd = 0;
        end
        if (v) begin
            if (q.size() < D) q.push_back(s);
            else set_ovf = 1;
        end
        e_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : e_ovf);
        e_unf = set_unf ? 1'b1 : (clr ? 1'b0 : e_unf);
    endtask

    task automatic check_all(input string nm);
        logic [7:0] act;
        logic [7:0] exp;
        act = {i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underflow};
        exp = {e_bclk, e_lr, e_sd, 3'(q.size()), e_ovf, e_unf};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: {bclk,lr,sd,lvl,ovf,unf} got %b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit en, input bit v, input bit clr, input logic [15:0] s);
        enable = en; in_valid = v; clr_flags = clr; in_sample = s;
        @(posedge clk);
        model_edge(en, v, clr, s);
        #1;
        check_all("cycle");
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0; in_valid = 1'b0; clr_flags = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Step enabled until the model reports a fall at (frame, p); bounded.
    task automatic run_to(input int fr, input int p, input int budget, input string nm);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            if (fall_p == p && (fr < 0 || fall_frame == fr)) hit = 1;
        end
        check({nm, "_reached"}, 64'(hit), 64'd1);
    endtask

    initial begin
        logic [63:0] cap;
        bit          done;
        int          falls;
        bit          prev;
        bit          reached;

        vectors = 0;
        miscompares = 0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Overfill while disabled, then clear the flag.
        tbl[0] = '{1'b0, 1'b1, 1'b0, 16'h1111, 3'd1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h2222, 3'd2, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h3333, 3'd3, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h4444, 3'd4, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h5555, 3'd4, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd4, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].en, tbl[i].v, tbl[i].clr, tbl[i].s);
            check($sformatf("tbl%0d_lvl_ovf", i), {fifo_level, overflow}, {tbl[i].lvl, tbl[i].ovf});
        end
        // Four frames carry samples 1..4, then the FIFO runs dry.
        idle(4 * 256 + 20, 1'b1);
        check("unf_after_drain", 64'(underflow), 64'd1);

        // Full FIFO with a write coincident with the first pop.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'(16'hA000 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h9999);
        check("full_pop_write", {fifo_level, overflow}, {3'd4, 1'b0});
        idle(300, 1'b1);

        // A single sample framed MSB-first in both slots.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 16'hA5C3);
        cap = '0;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            if (fall_p >= 1 && fall_frame == 0) cap[FW - fall_p] = i2s_sdata;
            if (fall_p == 0 && fall_frame == 1) begin
                cap[0] = i2s_sdata;
                done = 1;
            end
        end
        check("frame_a5c3", cap, 64'hA5C3_0000_A5C3_0000);

        // Underflow with no writes, clear, and re-set at next frame start.
        do_reset();
        run_to(0, 0, 20, "unf_first");
        check("unf_first", 64'(underflow), 64'd1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        check("unf_clr", 64'(underflow), 64'd0);
        run_to(1, 0, 300, "unf_again");
        check("unf_again", 64'(underflow), 64'd1);

        // Asynchronous reset mid-frame.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 16'hFFFF);
        step(1'b1, 1'b1, 1'b0, 16'h7777);
        run_to(0, 40, 200, "mid_frame");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async", {i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underflow}, '0);
        @(negedge clk);
        rst = 1'b0;
        run_to(0, 0, 20, "post_rst");
        check("post_rst_unf", 64'(underflow), 64'd1);
        idle(260, 1'b1);

        // Random traffic, enable toggling and flag clears.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) enable = ~enable;
            step(enable, ($urandom_range(59) == 0), ($urandom_range(99) == 0),
                 16'($urandom));
        end

        // SLOT_BITS = 16: first frame's R-slot LSB spills into p=0 of the next frame.
        enable = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        v16 = 1'b1; s16 = 16'h8001;
        @(posedge clk);
        #1;
        s16 = 16'h0001;
        @(posedge clk);
        #1;
        v16 = 1'b0;
        en16 = 1'b1;
        falls = 0;
        prev = 1'b0;
        reached = 0;
        for (int i = 0; i < 400 && !reached; i++) begin
            @(posedge clk);
            #1;
            if (prev && !bclk16) begin
                if (falls == 16) check("spill_r_msb", {lrclk16, sdata16}, 2'b11);
                if (falls == 32) check("spill_p0", {lrclk16, sdata16}, 2'b01);
                if (falls == 33) begin
                    check("spill_p1", {lrclk16, sdata16}, 2'b00);
                    reached = 1;
                end
                falls++;
            end
            prev = bclk16;
        end
        check("spill_reached", 64'(reached), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
